// File: rtl/action_sequencer.sv
// Epsilon-greedy action sequencer: fetches a Q-table row and picks one of four actions.
// Define ACTION_SEQ_EPS_DECAY_EN to enable per-episode epsilon decay.
module action_sequencer #(
    parameter logic [15:0] EPS_INIT  = 16'h0100,
    parameter logic [15:0] EPS_MIN   = 16'h000D,
    parameter logic [15:0] EPS_DEC   = 16'h0004,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  state_idx,
    input  logic        episode_done,
    output logic        qt_rd_en,
    output logic [5:0]  qt_addr,
    input  logic [63:0] qt_rd_data,
    output logic [3:0]  action,
    output logic        action_valid,
    output logic        explored,
    output logic        busy,
    output logic [15:0] epsilon
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SELECT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [15:0]   lfsr_r;
    logic          lfsr_fb_s;
    logic [15:0]   eps_r;
    logic [15:0]   eps_next_s;
    logic [63:0]   q_data_r;
    logic [5:0]    qt_addr_r;
    logic          qt_rd_en_r;
    logic [3:0]    action_r;
    logic          action_valid_r;
    logic          explored_r;
    logic          busy_r;
    logic          explore_s;
    logic [3:0]    sel_action_s;

    // Signed argmax over the four lanes; strict compare keeps the lowest index on ties.
    function automatic logic [3:0] greedy_pick(input logic [63:0] q);
        logic signed [15:0] best;
        logic [1:0]         idx;
        best = q[15:0];
        idx  = 2'd0;
        for (int a = 1; a < 4; a++) begin
            if ($signed(q[16*a +: 16]) > best) begin
                best = q[16*a +: 16];
                idx  = 2'(a);
            end
        end
        return 4'b0001 << idx;
    endfunction

    assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

    // Next-state logic for the fixed-length selection pipeline.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ:   state_s = ST_WAIT;
            ST_WAIT:   state_s = ST_SELECT;
            ST_SELECT: state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Explore/exploit decision from the current LFSR value and epsilon.
    always_comb begin
        explore_s = ({8'h00, lfsr_r[7:0]} < eps_r);
        if (explore_s) begin
            sel_action_s = 4'b0001 << lfsr_r[9:8];
        end else begin
            sel_action_s = greedy_pick(q_data_r);
        end
    end

`ifdef ACTION_SEQ_EPS_DECAY_EN
    logic [16:0] eps_diff_s;

    // Decay saturates at EPS_MIN, including when the subtraction wraps.
    always_comb begin
        eps_diff_s = {1'b0, eps_r} - {1'b0, EPS_DEC};
        if (!episode_done) begin
            eps_next_s = eps_r;
        end else if (eps_diff_s[16] || (eps_diff_s[15:0] < EPS_MIN)) begin
            eps_next_s = EPS_MIN;
        end else begin
            eps_next_s = eps_diff_s[15:0];
        end
    end
`else
    logic eps_unused_s;

    assign eps_unused_s = episode_done;
    assign eps_next_s   = eps_r;
`endif

    // State, LFSR and epsilon registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lfsr_r  <= LFSR_SEED;
            eps_r   <= EPS_INIT;
        end else begin
            state_r <= state_s;
            lfsr_r  <= {lfsr_r[14:0], lfsr_fb_s};
            eps_r   <= eps_next_s;
        end
    end

    // Datapath captures and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            qt_addr_r      <= 6'd0;
            qt_rd_en_r     <= 1'b0;
            q_data_r       <= 64'd0;
            action_r       <= 4'b0000;
            explored_r     <= 1'b0;
            action_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            qt_rd_en_r     <= (state_s == ST_READ);
            action_valid_r <= (state_s == ST_DONE);
            busy_r         <= (state_s != ST_IDLE);
            if ((state_r == ST_IDLE) && start) begin
                qt_addr_r <= state_idx;
            end
            if (state_r == ST_WAIT) begin
                q_data_r <= qt_rd_data;
            end
            if (state_r == ST_SELECT) begin
                action_r   <= sel_action_s;
                explored_r <= explore_s;
            end
        end
    end

    assign qt_rd_en     = qt_rd_en_r;
    assign qt_addr      = qt_addr_r;
    assign action       = action_r;
    assign action_valid = action_valid_r;
    assign explored     = explored_r;
    assign busy         = busy_r;
    assign epsilon      = eps_r;

endmodule

// File: tb/tb_action_sequencer.sv
// Self-checking bench for action_sequencer: three instances with different EPS_INIT
// driven by shared random stimulus, checked against a behavioural reference model.
module tb_action_sequencer;

    localparam logic [15:0] EPS_MIN = 16'h000D;
    localparam logic [15:0] EPS_DEC = 16'h0004;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam logic [2:0][15:0] INIT = {16'h0080, 16'h0100, 16'h0000};
`ifdef ACTION_SEQ_EPS_DECAY_EN
    localparam bit DECAY = 1'b1;
`else
    localparam bit DECAY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  state_idx;
    logic        episode_done;
    logic [63:0] qt_rd_data;

    logic [2:0]        rd_en;
    logic [2:0][5:0]   addr;
    logic [2:0][3:0]   act;
    logic [2:0]        av;
    logic [2:0]        expl;
    logic [2:0]        busy;
    logic [2:0][15:0]  eps;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] lfsr_m;
    int          eps_m [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        action_sequencer #(
            .EPS_INIT (INIT[g]),
            .EPS_MIN  (EPS_MIN),
            .EPS_DEC  (EPS_DEC),
            .LFSR_SEED(SEED)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .state_idx   (state_idx),
            .episode_done(episode_done),
            .qt_rd_en    (rd_en[g]),
            .qt_addr     (addr[g]),
            .qt_rd_data  (qt_rd_data),
            .action      (act[g]),
            .action_valid(av[g]),
            .explored    (expl[g]),
            .busy        (busy[g]),
            .epsilon     (eps[g])
        );
    end

    // Reference model: LFSR sequence and epsilon schedule.
    always @(posedge clk) begin
        if (rst) begin
            lfsr_m <= SEED;
        end else begin
            lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
        end
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                eps_m[i] <= int'(INIT[i]);
            end else if (DECAY && episode_done) begin
                eps_m[i] <= (eps_m[i] - int'(EPS_DEC) < int'(EPS_MIN)) ?
                            int'(EPS_MIN) : eps_m[i] - int'(EPS_DEC);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void expect_sel(input int e, input logic [15:0] l, input logic [63:0] d,
                                       output logic [3:0] a, output logic x);
        int best;
        int bv;
        int v;
        if (int'(l[7:0]) < e) begin
            x = 1'b1;
            a = 4'(1 << l[9:8]);
        end else begin
            x    = 1'b0;
            best = 0;
            bv   = int'($signed(d[15:0]));
            for (int k = 1; k < 4; k++) begin
                v = int'($signed(d[16*k +: 16]));
                if (v > bv) begin
                    bv   = v;
                    best = k;
                end
            end
            a = 4'(1 << best);
        end
    endfunction

    task automatic request(input logic [5:0] idx, input logic [63:0] data, input bit ign, input bit ep);
        logic [3:0] ea [3];
        logic       ee [3];
        @(negedge clk);
        start      = 1'b1;
        state_idx  = idx;
        qt_rd_data = {$urandom, $urandom};
        @(posedge clk); #1;
        start     = ign;
        state_idx = 6'($urandom);
        for (int i = 0; i < 3; i++) begin
            chk("rd_en_read", rd_en[i], 1'b1);
            chk("addr_read", addr[i], idx);
            chk("busy_read", busy[i], 1'b1);
            chk("valid_read", av[i], 1'b0);
        end
        @(posedge clk); #1;
        start      = 1'b0;
        qt_rd_data = data;
        for (int i = 0; i < 3; i++) chk("rd_en_wait", rd_en[i], 1'b0);
        @(posedge clk); #1;
        qt_rd_data   = {$urandom, $urandom};
        start        = ign;
        episode_done = ep;
        for (int i = 0; i < 3; i++) begin
            expect_sel(eps_m[i], lfsr_m, data, ea[i], ee[i]);
            chk("eps_select", eps[i], 64'(eps_m[i]));
            chk("valid_select", av[i], 1'b0);
        end
        @(posedge clk); #1;
        start        = 1'b0;
        episode_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("valid_done", av[i], 1'b1);
            chk("action", act[i], ea[i]);
            chk("explored", expl[i], ee[i]);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("valid_after", av[i], 1'b0);
            chk("busy_after", busy[i], 1'b0);
            chk("action_held", act[i], ea[i]);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) chk("no_queued_start", busy[i], 1'b0);
    endtask

    function automatic logic [15:0] pick_lane();
        case ($urandom_range(0, 4))
            0:       return 16'h0005;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [63:0] d;
        rst          = 1'b1;
        start        = 1'b0;
        episode_done = 1'b0;
        state_idx    = 6'd0;
        qt_rd_data   = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_action", act[i], 4'b0000);
            chk("rst_valid", av[i], 1'b0);
            chk("rst_explored", expl[i], 1'b0);
            chk("rst_rd_en", rd_en[i], 1'b0);
            chk("rst_addr", addr[i], 6'd0);
            chk("rst_eps", eps[i], INIT[i]);
        end
        rst = 1'b0;

        request(6'd5, 64'h000C_0001_0002_0003, 1'b0, 1'b0);
        chk("greedy_max", act[0], 4'b1000);
        chk("greedy_max_expl", expl[0], 1'b0);
        chk("always_explore", expl[1], 1'b1);
        request(6'd17, 64'h0005_0005_0005_0005, 1'b0, 1'b0);
        chk("greedy_tie", act[0], 4'b0001);
        request(6'd63, 64'h0000_FF00_8000_FFFF, 1'b1, 1'b0);
        chk("greedy_signed", act[0], 4'b1000);

        for (int n = 0; n < 40; n++) begin
            d = {pick_lane(), pick_lane(), pick_lane(), pick_lane()};
            request(6'($urandom), d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            episode_done = 1'b1;
            @(posedge clk); #1;
            episode_done = 1'b0;
            for (int i = 0; i < 3; i++) chk("eps_decay", eps[i], 64'(eps_m[i]));
        end
        chk("eps_final", eps[1], DECAY ? 16'h000D : 16'h0100);
        chk("eps_final_low_init", eps[0], DECAY ? 16'h000D : 16'h0000);

        @(negedge clk);
        start     = 1'b1;
        state_idx = 6'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_busy", busy[i], 1'b0);
            chk("abort_action", act[i], 4'b0000);
            chk("abort_valid", av[i], 1'b0);
        end
        repeat (6) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) chk("abort_no_valid", av[i], 1'b0);
        end
        request(6'd33, 64'h1234_0100_7FFF_8001, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
